// File: rtl/ram_arbiter_if.sv
// Bundle between the two RAM clients, the arbiter and the shared registered-read RAM.
// Requester-side vectors are packed as [1:0] so that bit N belongs to requester N.
interface ram_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [1:0]            req;
  logic [1:0]            we;
  logic [1:0]            lock;
  logic [1:0][WIDTH-1:0] addr;
  logic [1:0][WIDTH-1:0] wdata;
  logic [1:0]            gnt;
  logic [1:0]            rvalid;
  logic [WIDTH-1:0]      rdata;

  logic                  ram_wen;
  logic [WIDTH-1:0]      ram_w_addr;
  logic [WIDTH-1:0]      ram_r_addr;
  logic [WIDTH-1:0]      ram_data_in;
  logic [WIDTH-1:0]      ram_data_out;

  modport slave (
    input  req, we, lock, addr, wdata, ram_data_out,
    output gnt, rvalid, rdata, ram_wen, ram_w_addr, ram_r_addr, ram_data_in
  );

  modport master (
    output req, we, lock, addr, wdata, ram_data_out,
    input  gnt, rvalid, rdata, ram_wen, ram_w_addr, ram_r_addr, ram_data_in
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one registered-read RAM between two clients, with a
// per-requester lock that keeps ownership across read-modify-write sequences.
module ram_arbiter (
  input  logic          clk_i,
  input  logic          reset_ni,
  ram_arbiter_if.slave  bus
);

  logic       last_q, last_d;
  logic       owner_valid_q, owner_valid_d;
  logic       owner_q, owner_d;
  logic [1:0] rd_pend_q, rd_pend_d;
  logic [1:0] gnt;
  logic       winner;

  // Grant is combinational and forced low while reset is held.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    gnt = 2'b00;
    if (!reset_ni) begin
      gnt = 2'b00;
    end else if (owner_valid_q) begin
      gnt[owner_q] = bus.req[owner_q];
    end else begin
      unique case (bus.req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign winner = gnt[1];

  always_comb begin
    last_d          = last_q;
    owner_valid_d   = owner_valid_q;
    owner_d         = owner_q;
    rd_pend_d       = gnt & ~bus.we;
    bus.ram_wen     = 1'b0;
    bus.ram_w_addr  = '0;
    bus.ram_r_addr  = '0;
    bus.ram_data_in = '0;
    if (|gnt) begin
      last_d          = winner;
      owner_valid_d   = bus.lock[winner];
      if (bus.lock[winner]) owner_d = winner;
      bus.ram_wen     = bus.we[winner];
      bus.ram_w_addr  = bus.addr[winner];
      bus.ram_r_addr  = bus.addr[winner];
      bus.ram_data_in = bus.wdata[winner];
    end
  end

  // last resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      last_q        <= 1'b1;
      owner_valid_q <= 1'b0;
      owner_q       <= 1'b0;
      rd_pend_q     <= 2'b00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      last_q        <= last_d;
      owner_valid_q <= owner_valid_d;
      owner_q       <= owner_d;
      rd_pend_q     <= rd_pend_d;
    end
  end

  assign bus.gnt    = gnt;
  assign bus.rvalid = rd_pend_q;
  assign bus.rdata  = bus.ram_data_out;

endmodule
